// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32 core: sequences ALU, register file, memory port and IR.
// Latency: lw 5 cycles, beq 3, sw/R/I/jal 4 with mem_ready high; each memory wait cycle adds one.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; the enables that depend on memory are gated by it.
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [1:0] aluop,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       halted
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        aluop         = 2'b00;
        reg_write     = 1'b0;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        halted        = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                state_nxt  = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALU precomputes oldPC + imm so BEQ can use it as the target
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYP:      state_nxt = S_EXECUTER;
                    OP_ITYP:      state_nxt = S_EXECUTEI;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default: begin
                        illegal_instr = 1'b1;
                        state_nxt     = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src   = 1'b1;
                state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                state_nxt  = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                aluop     = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluop     = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                aluop      = 2'b01;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_HALT: begin
                halted    = 1'b1;
                state_nxt = S_HALT;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into a list of expected per-cycle output steps.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal_instr, halted;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, aluop;
    logic       h_pc_write, h_adr_src, h_mem_write, h_ir_write, h_reg_write, h_instr_done, h_illegal_instr, h_halted;
    logic [1:0] h_result_src, h_alu_src_a, h_alu_src_b, h_imm_src, h_aluop;

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .aluop(aluop), .reg_write(reg_write), .instr_done(instr_done),
        .illegal_instr(illegal_instr), .halted(halted)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_halt (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(h_pc_write), .adr_src(h_adr_src), .mem_write(h_mem_write), .ir_write(h_ir_write),
        .result_src(h_result_src), .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .imm_src(h_imm_src),
        .aluop(h_aluop), .reg_write(h_reg_write), .instr_done(h_instr_done),
        .illegal_instr(h_illegal_instr), .halted(h_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pcw, adr, mw, irw, rs[2], sa[2], sb[2], imm[2], aop[2], rw, done, ill, hlt}
    logic [17:0] obs;
    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                  imm_src, aluop, reg_write, instr_done, illegal_instr, halted};

    localparam logic [17:0] B_PCW  = 18'h1 << 17;
    localparam logic [17:0] B_IRW  = 18'h1 << 14;
    localparam logic [17:0] B_DONE = 18'h1 << 2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [17:0] base;     // outputs that hold regardless of inputs
        logic [17:0] rdy;      // outputs that follow mem_ready
        bit          wait_mem; // step repeats until mem_ready
        bit          br;       // pc_write follows zero
    } step_t;

    step_t q[$];
    int    idx;

    function automatic logic [17:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] aop, input logic rw, input logic done,
                                       input logic ill);
        return {pcw, adr, mw, 1'b0, rs, sa, sb, 2'b00, aop, rw, done, ill, 1'b0};
    endfunction

    function automatic step_t st(input logic [17:0] base, input logic [17:0] rdy, input bit w, input bit br);
        step_t s;
        s.base = base; s.rdy = rdy; s.wait_mem = w; s.br = br;
        return s;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    task automatic build(input logic [6:0] o);
        step_t aluwb;
        step_t memadr;
        aluwb  = st(mk(0,0,0,2'b00,2'b00,2'b00,2'b00,1,1,0), 18'h0, 0, 0);
        memadr = st(mk(0,0,0,2'b00,2'b10,2'b01,2'b00,0,0,0), 18'h0, 0, 0);
        q.delete();
        idx = 0;
        q.push_back(st(mk(0,0,0,2'b10,2'b00,2'b10,2'b00,0,0,0), B_PCW | B_IRW, 1, 0));
        case (o)
            7'b0000011: begin
                q.push_back(st(mk(0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), 18'h0, 0, 0));
                q.push_back(memadr);
                q.push_back(st(mk(0,1,0,2'b00,2'b00,2'b00,2'b00,0,0,0), 18'h0, 1, 0));
                q.push_back(st(mk(0,0,0,2'b01,2'b00,2'b00,2'b00,1,1,0), 18'h0, 0, 0));
            end
            7'b0100011: begin
                q.push_back(st(mk(0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), 18'h0, 0, 0));
                q.push_back(memadr);
                q.push_back(st(mk(0,1,1,2'b00,2'b00,2'b00,2'b00,0,0,0), B_DONE, 1, 0));
            end
            7'b0110011: begin
                q.push_back(st(mk(0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), 18'h0, 0, 0));
                q.push_back(st(mk(0,0,0,2'b00,2'b10,2'b00,2'b10,0,0,0), 18'h0, 0, 0));
                q.push_back(aluwb);
            end
            7'b0010011: begin
                q.push_back(st(mk(0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), 18'h0, 0, 0));
                q.push_back(st(mk(0,0,0,2'b00,2'b10,2'b01,2'b10,0,0,0), 18'h0, 0, 0));
                q.push_back(aluwb);
            end
            7'b1100011: begin
                q.push_back(st(mk(0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), 18'h0, 0, 0));
                q.push_back(st(mk(0,0,0,2'b00,2'b10,2'b00,2'b01,0,1,0), 18'h0, 0, 1));
            end
            7'b1101111: begin
                q.push_back(st(mk(0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,0), 18'h0, 0, 0));
                q.push_back(st(mk(1,0,0,2'b00,2'b01,2'b10,2'b00,0,0,0), 18'h0, 0, 0));
                q.push_back(aluwb);
            end
            default:
                q.push_back(st(mk(0,0,0,2'b00,2'b01,2'b01,2'b00,0,0,1), 18'h0, 0, 0));
        endcase
    endtask

    function automatic logic [17:0] expect_now();
        logic [17:0] e;
        step_t s;
        s = q[idx];
        e = s.base | (mem_ready ? s.rdy : 18'h0) | ((s.br && zero) ? B_PCW : 18'h0);
        e[7:6] = imm_of(op);
        return e;
    endfunction

    function automatic logic [6:0] pick_op();
        logic [6:0] tbl [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b1111111, 7'b0110111};
        return tbl[$urandom_range(0, 7)];
    endfunction

    logic [6:0]  cur_op;
    logic [17:0] e;
    int          done_dut = 0;
    int          done_ref = 0;

    initial begin
        rst_n     = 1'b0;
        op        = 7'b0000011;
        mem_ready = 1'b1;
        zero      = 1'b0;
        cur_op    = 7'b0000011;
        build(cur_op);
        #12;
        check("reset_fetch_rdy", obs, expect_now());
        check("reset_halted", {31'h0, h_halted}, 32'h0);
        mem_ready = 1'b0;
        #1;
        check("reset_fetch_stall", obs, expect_now());
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            op        = cur_op;
            mem_ready = ($urandom_range(0, 9) < 7);
            zero      = $urandom_range(0, 1) == 1;
            #1;
            e = expect_now();
            check("cycle", obs, e);
            if (e[2]) done_ref++;
            if (instr_done) done_dut++;
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #1 build(cur_op);
                #1;
                check("reset_abort", obs, expect_now());
                rst_n = 1'b1;
            end
            if (!(q[idx].wait_mem && !mem_ready)) begin
                idx++;
                if (idx == q.size()) begin
                    cur_op = pick_op();
                    build(cur_op);
                end
            end
        end
        check("instr_done_count", done_dut, done_ref);

        @(negedge clk);
        rst_n     = 1'b0;
        op        = 7'b1111111;
        mem_ready = 1'b1;
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("illegal_pulse_halt", {31'h0, h_illegal_instr}, 32'h1);
        check("illegal_pulse_ret", {31'h0, illegal_instr}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            op        = pick_op();
            mem_ready = $urandom_range(0, 1) == 1;
            #1;
            check("halted_stays", {31'h0, h_halted}, 32'h1);
            check("halt_enables", {28'h0, h_pc_write, h_ir_write, h_mem_write, h_reg_write}, 32'h0);
            check("no_halt_param0", {31'h0, halted}, 32'h0);
        end
        rst_n = 1'b0;
        #1;
        check("halt_cleared", {31'h0, h_halted}, 32'h0);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle RV32 core. It sequences the shared ALU, register file, memory port and instruction register over several cycles per instruction. It drives the 2-bit aluop consumed by ALU_decoder, plus the datapath mux selects and write enables. It supports lw, sw, R-type, I-type ALU, beq and jal, and stalls on a memory-ready handshake.

Parameters:
HALT_ON_ILLEGAL, 0, 1: an illegal opcode parks the FSM in HALT until reset. 0: the FSM returns to FETCH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  instr[6:0], taken from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory accepted/returned data this cycle
pc_write  output  1  PC register enable
adr_src  output  1  memory address mux: 0 = PC, 1 = ALU result register
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register / oldPC enable
result_src  output  2  result mux: 00 = ALUOut, 01 = data, 10 = ALU result
alu_src_a  output  2  ALU A mux: 00 = PC, 01 = oldPC, 10 = rs1 register
alu_src_b  output  2  ALU B mux: 00 = rs2 register, 01 = imm, 10 = constant 4
imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
aluop  output  2  to ALU_decoder: 00 = add, 01 = sub, 10 = funct-decoded
reg_write  output  1  register file write enable
instr_done  output  1  one-cycle pulse in the final state of each instruction
illegal_instr  output  1  one-cycle pulse when an unsupported opcode is decoded
halted  output  1  high while in the HALT state

Behaviour:
- State register: 4 bits, asynchronous clear to FETCH when rst_n = 0. While in reset, outputs take FETCH values with mem_ready gating applied.
- Moore outputs decoded from state. Every output not listed for a state is 0.
- pc_write = pc_update | (branch & zero). pc_update and branch are internal signals.
- imm_src is combinational from op, independent of state:
  - 0000011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - 0010011 -> 00
  - any other opcode -> 00
- Per-state outputs:
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10. ir_write=pc_update=mem_ready.
  - DECODE: alu_src_a=01, alu_src_b=01, aluop=00 (computes branch target).
  - MEMADR: alu_src_a=10, alu_src_b=01, aluop=00.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1, instr_done=1.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. instr_done=mem_ready.
  - EXECUTER: alu_src_a=10, alu_src_b=00, aluop=10.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, aluop=10.
  - ALUWB: result_src=00, reg_write=1, instr_done=1.
  - BEQ: alu_src_a=10, alu_src_b=00, aluop=01, result_src=00, branch=1, instr_done=1.
  - JAL: alu_src_a=01, alu_src_b=10, aluop=00, result_src=00, pc_update=1.
  - HALT: halted=1, all enables 0.
- Transitions:
  - FETCH -> DECODE if mem_ready, else hold.
  - DECODE, by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> illegal_instr=1 that cycle; next state HALT if HALT_ON_ILLEGAL, else FETCH.
  - MEMADR: op=0000011 -> MEMREAD, else MEMWRITE.
  - MEMREAD -> MEMWB if mem_ready, else hold. MEMWB -> FETCH.
  - MEMWRITE -> FETCH if mem_ready, else hold with mem_write held high.
  - EXECUTER, EXECUTEI, JAL -> ALUWB -> FETCH.
  - BEQ -> FETCH.
  - HALT -> HALT.
  - Unused encodings -> FETCH.
- Latency with mem_ready constantly 1:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
- Each memory wait cycle adds 1 cycle. pc_write asserts at most once per FETCH, regardless of stall length.
- zero is sampled only in BEQ; it is ignored in every other state.
- Reset asserted mid-instruction aborts it immediately. No write enable is asserted after the reset edge, except the mem_ready-gated FETCH enables.

Test Plan:
- Reset with op=0000011, mem_ready=1 -> after release: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1, result_src=01 in cycle 5; instr_done pulses once; imm_src=00.
- sw op=0100011, mem_ready low for 3 cycles in MEMWRITE -> mem_write high for 4 cycles; instr_done only in the last; back to FETCH; imm_src=01.
- beq op=1100011, zero=1 -> pc_write=1 in cycle 3, aluop=01. Repeat with zero=0 -> pc_write=0 in cycle 3.
- R-type op=0110011 -> EXECUTER has aluop=10, alu_src_b=00. jal op=1101111 -> JAL has pc_write=1, alu_src_a=01, alu_src_b=10, then ALUWB with reg_write=1.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=pc_write=0 while stalled; exactly one pulse when mem_ready rises.
- op=1111111: HALT_ON_ILLEGAL=0 -> illegal_instr pulse, then FETCH. HALT_ON_ILLEGAL=1 -> halted=1 and stays. rst_n pulse low mid-MEMREAD -> immediate FETCH.
